// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: operation codes, FSM states and
// the default datapath width. Helpers classify codes by execution class.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND      = 4'b0000,
        OP_OR       = 4'b0001,
        OP_ADD      = 4'b0010,
        OP_XOR      = 4'b0011,
        OP_SLL      = 4'b0100,
        OP_SRL      = 4'b0101,
        OP_SUB      = 4'b0110,
        OP_SLT      = 4'b0111,
        OP_SLTU     = 4'b1000,
        OP_SRA      = 4'b1001,
        OP_MUL      = 4'b1010,
        OP_MULHU    = 4'b1011,
        OP_DIVU     = 4'b1100,
        OP_REMU     = 4'b1101,
        OP_ADD_ALT0 = 4'b1110,
        OP_ADD_ALT1 = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_muldiv(alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide.
// A start pulse loads the operands; exactly WIDTH step cycles follow and
// 'done' is raised combinationally during the last step, with 'res' holding
// the value the final step produces, so the caller can capture it that edge.
// Divide by zero falls out of the restoring algorithm naturally: every trial
// subtraction succeeds (quotient all ones) and the remainder is the dividend.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    alu_op_e          op_p0;
    // x: product high half / partial remainder; y: multiplier+low half / dividend+quotient
    logic [WIDTH-1:0] x_p0, y_p0, m_p0;
    logic [WIDTH-1:0] x_nxt, y_nxt;
    logic [WIDTH:0]   sum, shifted, trial;
    logic             is_div;

    assign is_div = (op_p0 == OP_DIVU) || (op_p0 == OP_REMU);
    assign done   = busy && (cnt == CW'(WIDTH - 1));

    // One algorithm step: conditional add-then-shift, or shift-then-trial-subtract
    always_comb begin
        sum     = {1'b0, x_p0} + (y_p0[0] ? {1'b0, m_p0} : '0);
        shifted = {x_p0, y_p0[WIDTH-1]};
        trial   = shifted - {1'b0, m_p0};
        if (is_div) begin
            x_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            y_nxt = {y_p0[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            x_nxt = sum[WIDTH:1];
            y_nxt = {sum[0], y_p0[WIDTH-1:1]};
        end
    end

    // Select which half of the final step is the answer
    always_comb begin
        case (op_p0)
            OP_MULHU: res = x_nxt;
            OP_REMU:  res = x_nxt;
            default:  res = y_nxt;
        endcase
    end

    // Load on start, then iterate until the last step has been taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            op_p0 <= OP_MUL;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            op_p0 <= op;
            x_p0  <= '0;
            y_p0  <= a;
            m_p0  <= b;
        end else if (busy) begin
            x_p0 <= x_nxt;
            y_p0 <= y_nxt;
            cnt  <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with a valid/ready request and result
// handshake. Logic/arithmetic/compare ops finish in one cycle, shifts walk
// one bit per cycle, and multiply/divide iterate for WIDTH cycles.
// Optional feature macro: ALU_EXEC_MULDIV_EN -- when defined, codes
// 1010..1101 run on the iterative multiply/divide engine; when undefined no
// multiply/divide hardware exists and those codes execute as ADD.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    state_e           state;
    alu_op_e          req_op;
    alu_op_e          op_p0;
    logic [WIDTH-1:0] work_p0;
    logic [4:0]       cnt;
    logic             accept;
    logic [WIDTH-1:0] fast_res;
    logic [WIDTH-1:0] shift_nxt;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    // Single-cycle operations; a zero-distance shift passes op_a through and
    // every code without a dedicated path (including 1110/1111) adds.
    function automatic logic [WIDTH-1:0] fast_op(alu_op_e op, logic [WIDTH-1:0] a,
                                                 logic [WIDTH-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  return a;
            OP_SRL:  return a;
            OP_SRA:  return a;
            default: return a + b;
        endcase
    endfunction

    assign req_op   = alu_op_e'(alu_ctrl);
    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign fast_res = fast_op(req_op, op_a, op_b);

    // One-bit shift step on the working value
    always_comb begin
        case (op_p0)
            OP_SLL:  shift_nxt = {work_p0[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_nxt = {1'b0, work_p0[WIDTH-1:1]};
            OP_SRA:  shift_nxt = {work_p0[WIDTH-1], work_p0[WIDTH-1:1]};
            default: shift_nxt = work_p0;
        endcase
    end

`ifdef ALU_EXEC_MULDIV_EN
    localparam logic MD_EN = 1'b1;
    logic md_start;
    assign md_start = accept && is_muldiv(req_op);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (req_op),
        .a     (op_a),
        .b     (op_b),
        .done  (md_done),
        .res   (md_result)
    );
`else
    localparam logic MD_EN = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    // Request/iterate/present FSM with registered result, zero and out_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            cnt       <= '0;
            op_p0     <= OP_AND;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_p0   <= req_op;
                        work_p0 <= op_a;
                        cnt     <= op_b[4:0];
                        if (is_shift(req_op) && (op_b[4:0] != 5'd0)) begin
                            state <= ST_BUSY;
                        end else if (MD_EN && is_muldiv(req_op)) begin
                            state <= ST_BUSY;
                        end else begin
                            state     <= ST_DONE;
                            result    <= fast_res;
                            zero      <= (fast_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (MD_EN && is_muldiv(op_p0)) begin
                        if (md_done) begin
                            state     <= ST_DONE;
                            result    <= md_result;
                            zero      <= (md_result == '0);
                            out_valid <= 1'b1;
                        end
                    end else begin
                        work_p0 <= shift_nxt;
                        cnt     <= cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            state     <= ST_DONE;
                            result    <= shift_nxt;
                            zero      <= (shift_nxt == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: fixed vector table, randomized ops
// against a behavioural model, and hand-written stall/reset sequences.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural reference: what each code means arithmetically
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] s;
        int                 sh;
        sh = int'(b[4:0]);
        p  = {32'd0, a} * {32'd0, b};
        s  = $signed(a) >>> sh;
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd3:  return a ^ b;
            4'd4:  return a << sh;
            4'd5:  return a >> sh;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return s;
`ifdef ALU_EXEC_MULDIV_EN
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
`endif
            default: return a + b;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'd4 || c == 4'd5 || c == 4'd9) return int'(b[4:0]) + 1;
`ifdef ALU_EXEC_MULDIV_EN
        if (c >= 4'd10 && c <= 4'd13) return W + 1;
`endif
        return 1;
    endfunction

    // Issue one request from idle, measure latency, check and consume result.
    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string tag);
        int lat;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        chk({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, result, exp);
        chk({tag, " zero"}, 32'(zero), 32'(exp == 32'd0));
        chk({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;

        // Fixed vectors: code, a, b, expected result, latency
        tbl.push_back('{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1});
        tbl.push_back('{4'b0110, 32'd5,         32'd5,         32'd0,         1});
        tbl.push_back('{4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 1});
        tbl.push_back('{4'b0001, 32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F, 1});
        tbl.push_back('{4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1});
        tbl.push_back('{4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1});
        tbl.push_back('{4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1});
        tbl.push_back('{4'b0110, 32'd0,         32'd1,         32'hFFFF_FFFF, 1});
        tbl.push_back('{4'b1001, 32'h8000_0000, 32'd4,         32'hF800_0000, 5});
        tbl.push_back('{4'b1001, 32'h8000_0000, 32'd0,         32'h8000_0000, 1});
        tbl.push_back('{4'b0101, 32'h8000_0000, 32'd4,         32'h0800_0000, 5});
        tbl.push_back('{4'b0100, 32'd1,         32'd31,        32'h8000_0000, 32});
        tbl.push_back('{4'b0100, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1});
        tbl.push_back('{4'b1110, 32'd10,        32'd20,        32'd30,        1});
        tbl.push_back('{4'b1111, 32'hFFFF_FFFF, 32'd1,         32'd0,         1});
`ifdef ALU_EXEC_MULDIV_EN
        tbl.push_back('{4'b1010, 32'd6,         32'd7,         32'd42,        W + 1});
        tbl.push_back('{4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W + 1});
        tbl.push_back('{4'b1100, 32'd100,       32'd0,         32'hFFFF_FFFF, W + 1});
        tbl.push_back('{4'b1101, 32'd100,       32'd0,         32'd100,       W + 1});
        tbl.push_back('{4'b1100, 32'd100,       32'd7,         32'd14,        W + 1});
        tbl.push_back('{4'b1101, 32'd100,       32'd7,         32'd2,         W + 1});
`else
        tbl.push_back('{4'b1010, 32'd6,         32'd7,         32'd13,        1});
        tbl.push_back('{4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1});
        tbl.push_back('{4'b1100, 32'd100,       32'd0,         32'd100,       1});
        tbl.push_back('{4'b1101, 32'd100,       32'd7,         32'd107,       1});
`endif

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'd0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        foreach (tbl[i]) begin
            run_op(tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Result held in DONE while the consumer stalls; new requests ignored
        alu_ctrl = 4'b0010;
        op_a     = 32'd2;
        op_b     = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            alu_ctrl = 4'b0110;
            op_a     = 32'd9;
            op_b     = 32'd1;
            in_valid = 1'b1;
            chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d result", k), result, 32'd5);
            chk($sformatf("stall%0d zero", k), 32'(zero), 32'd0);
            chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall consume in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall after out_valid", 32'(out_valid), 32'd0);
        chk("stall after in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall no ghost result", 32'(out_valid), 32'd0);

        // Reset in the middle of a divide
        alu_ctrl = 4'b1100;
        op_a     = 32'd100;
        op_b     = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort result", result, 32'd0);
        run_op(4'b0010, 32'd2, 32'd3, 32'd5, 1, "abort add");
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("abort no late result", 32'(seen), 32'd0);
        end

        // Randomized operations against the model
        for (int n = 0; n < 200; n++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 300);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            run_op(c, a, b, model(c, a, b), model_lat(c, b), $sformatf("rnd%0d op%0d", n, c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 alu_ctrl  input  4  operation code from the ALU control decoder.
REQ-007 op_a  input  WIDTH  first operand.
REQ-008 op_b  input  WIDTH  second operand; shift amount in op_b[4:0].
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result equals 0 (branch compare).

Function
REQ-013 Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SRA, 1010 MUL (low WIDTH), 1011 MULHU (high WIDTH, unsigned), 1100 DIVU, 1101 REMU; 1110/1111 SHALL execute as ADD.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-015 Request accepted when in_valid && in_ready; operands and code registered that cycle.
REQ-016 AND/OR/XOR/ADD/SUB/SLT/SLTU: IDLE->DONE, out_valid asserted cycle after accept (latency 1).
REQ-017 Shifts: one bit per cycle in BUSY; shamt=N gives out_valid N+1 cycles after accept; shamt 0 goes IDLE->DONE (latency 1).
REQ-018 SRA replicates sign bit each step; SRL/SLL fill zero.
REQ-019 MUL/MULHU: shift-add, exactly WIDTH BUSY cycles, out_valid WIDTH+1 cycles after accept.
REQ-020 DIVU/REMU: restoring division, exactly WIDTH BUSY cycles, latency WIDTH+1.
REQ-021 Divide by zero: DIVU result all-ones, REMU result op_a; same latency, no error signal.
REQ-022 ADD/SUB/MUL wrap modulo 2^WIDTH; no overflow flag.
REQ-023 DONE: result, zero, out_valid held stable until out_ready; out_valid && out_ready -> IDLE.
REQ-024 No new request accepted in the cycle the result is consumed (in_ready rises next cycle).
REQ-025 zero computed from registered result, valid whenever out_valid=1.

Reset
REQ-026 rst_n=0 on a clock edge: state IDLE, out_valid=0, result=0, zero=1, iteration counter=0, in_ready=1 after release.
REQ-027 Reset mid-operation (BUSY or DONE) aborts; no partial result ever presented.

Configuration
REQ-028 Macro ALU_EXEC_MULDIV_EN defined: codes 1010-1101 behave per REQ-019..021.
REQ-029 Macro undefined: no multiply/divide datapath compiled; codes 1010-1101 execute as ADD with latency 1.

Structure
REQ-030 Package alu_pkg holds alu_op_e enum (4-bit codes of REQ-013), FSM state enum, WIDTH default constant.
REQ-031 Iterative multiply/divide in sub-module alu_muldiv_iter (start/done handshake), instantiated only under ALU_EXEC_MULDIV_EN.

Verification
REQ-032 ADD 0x7FFFFFFF+1 -> result 0x80000000, latency 1; SUB 5-5 -> result 0, zero=1.
REQ-033 SRA op_a=0x80000000, shamt 4 -> 0xF8000000, out_valid 5 cycles after accept; shamt 0 -> latency 1.
REQ-034 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, latency 33; DIVU 100/0 -> 0xFFFFFFFF, REMU 100/0 -> 100.
REQ-035 out_ready held 0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored.
REQ-036 rst_n=0 at BUSY cycle 10 of DIVU -> next cycle IDLE, out_valid=0, following ADD 2+3 returns 5.
REQ-037 Build without ALU_EXEC_MULDIV_EN: code 1010, 6 and 7 -> result 13, latency 1.
